cfg_serial_tx: RTL and testbench
================================

# cfg_serial_tx

Serial configuration transmitter that drives the backend's `i_sclk`/`i_sdin` configuration port from the controller side.
- Accepts a parallel gain word over a start/busy handshake and shifts it out MSB first on a divided serial clock.
- After the frame, waits for the backend's ready indication with a timeout, then reports completion and latches the backend's VCO comparison result.

## Interface
- `CLK_DIV`, 4: `o_sclk` half-period in `i_clk` cycles; legal range 1..255.
- `READY_TIMEOUT`, 64: maximum `i_clk` cycles spent in WAIT_RDY; legal range 1..65535.
- `i_clk` input 1: sole clock; all logic on rising edge.
- `i_resetbAll` input 1: reset, synchronous and active-low.
- `i_start` input 1: request a transfer; sampled only in IDLE.
- `i_gainA1` input 3: gain A1 value, captured on accepted start.
- `i_gainA2` input 2: gain A2 value, captured on accepted start.
- `i_ready` input 1: backend ready (backend `o_ready`).
- `i_vco1_fast` input 1: backend VCO comparison (backend `o_vco1_fast`).
- `o_sclk` output 1: serial clock to backend.
- `o_sdin` output 1: serial data to backend.
- `o_busy` output 1: transfer in progress.
- `o_done` output 1: one-cycle pulse on successful completion.
- `o_timeout` output 1: sticky timeout flag.
- `o_vco1_fast` output 1: `i_vco1_fast` captured at completion.

## Operation
- Frame word is 5 bits: {gainA2[1:0], gainA1[2:0]}. Transmission order: bit4 first, bit0 last, so after 5 shifts the receiver holds gainA2 in [4:3] and gainA1 in [2:0].
- States: IDLE, SHIFT_LO, SHIFT_HI, WAIT_RDY, DONE.
  - IDLE: `o_sclk`=0, `o_sdin`=0, `o_busy`=0.
    - `i_start`=1: capture the word, clear `o_timeout`, set bit index to 4, go to SHIFT_LO.
  - SHIFT_LO: `o_sclk`=0, `o_sdin`=current bit; lasts CLK_DIV cycles, then SHIFT_HI.
  - SHIFT_HI: `o_sclk`=1, `o_sdin` held; lasts CLK_DIV cycles.
    - If bit index is 0: go to WAIT_RDY.
    - Otherwise: decrement bit index and return to SHIFT_LO.
  - WAIT_RDY: `o_sclk`=0, `o_sdin`=0; cycle counter starts at 0.
    - `i_ready`=1: go to DONE.
    - Counter reaches READY_TIMEOUT-1 with `i_ready`=0: set `o_timeout`=1 and return to IDLE.
  - DONE: `o_done`=1 for one cycle, `o_vco1_fast`<=`i_vco1_fast`, then IDLE.
- `o_busy`=1 in every state except IDLE.
- `i_start` outside IDLE is ignored and is not queued.
- `o_sdin` changes only while `o_sclk`=0, giving CLK_DIV cycles of setup and hold around each rising edge.
- `i_ready` already 1 on WAIT_RDY entry: DONE on the next cycle (no minimum wait).
- Both the phase counter and the timeout counter are sized by `$clog2` of their parameter plus 1. No wrap is possible.

## Timing
- Reset (`i_resetbAll`=0 at a clock edge): state IDLE, all counters 0, captured word 0.
  - Output values: `o_sclk`=0, `o_sdin`=0, `o_busy`=0, `o_done`=0, `o_timeout`=0, `o_vco1_fast`=0.
  - Reset mid-frame aborts the frame; outputs reach reset values on that edge.
- Start accepted at edge N: `o_busy`=1 and bit4 on `o_sdin` from N+1.
- First `o_sclk` rise at N+1+CLK_DIV; frame occupies 10·CLK_DIV cycles; WAIT_RDY entered at N+1+10·CLK_DIV.
- `i_ready` seen high in WAIT_RDY at edge M: `o_done`=1 and `o_vco1_fast` updated during M+1; `o_busy`=0 from M+2.
- Timeout: `o_timeout`=1 and `o_busy`=0 from READY_TIMEOUT cycles after WAIT_RDY entry. `o_timeout` stays high until the next accepted start or reset.
- Back-to-back: a start can be accepted on the first IDLE cycle after DONE or timeout.

## Structure
- Shared package `cfg_pkg`:
  - state enum.
  - `CFG_WORD_W`=5.
  - field positions `GAINA2_MSB`=4, `GAINA2_LSB`=3, `GAINA1_MSB`=2, `GAINA1_LSB`=0.
  - The backend receiver uses the same field constants.
- One sub-module, `cfg_clkdiv_phase`: a CLK_DIV phase counter with a terminal-count pulse and synchronous restart. The FSM, shift register and timeout counter stay in the top module.

## Test plan
- CLK_DIV=2, gainA1=3'b101, gainA2=2'b10, start at cycle 0 -> `o_sdin` bits at the 5 `o_sclk` rises are 1,0,1,0,1; 5 rising edges total; `o_busy` high for 20 cycles before WAIT_RDY.
- Same frame into the backend model with `i_vco1_fast`=1 -> backend reports gainA1=5, gainA2=2; `o_done` pulses once; `o_vco1_fast`=1.
- `i_ready` held 0, READY_TIMEOUT=8 -> `o_timeout`=1 and `o_busy`=0 exactly 8 cycles after WAIT_RDY entry; no `o_done`. Next start clears `o_timeout`.
- `i_start` pulsed during SHIFT_HI of bit 2 with different gains -> ignored; the frame completes with the original word; no second frame.
- `i_resetbAll` low for one cycle during bit 3 -> all outputs at reset values on that edge; a new start sends a complete 5-bit frame.
- CLK_DIV=1 with `i_ready` already 1 -> 10-cycle frame; `o_done` one cycle after WAIT_RDY entry.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared definitions for the serial configuration link between the
// controller-side transmitter and the backend receiver.
//   cfg_state_t  : transmitter FSM states
//   CFG_WORD_W   : width of the serial configuration frame
//   GAINA*_MSB/LSB : field positions inside the frame, also used by the
//                  backend receiver to split the shifted-in word
//   pack_word    : builds the frame word from the two gain fields
package cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_WAIT_RDY,
      ST_DONE
   } cfg_state_t;

   localparam int CFG_WORD_W = 5;

   localparam int GAINA2_MSB = 4;
   localparam int GAINA2_LSB = 3;
   localparam int GAINA1_MSB = 2;
   localparam int GAINA1_LSB = 0;

   // Places gainA2 in the upper field and gainA1 in the lower field so the
   // receiver ends up with the same layout after an MSB-first transfer.
   function automatic logic [CFG_WORD_W-1:0] pack_word(
      input logic [GAINA2_MSB-GAINA2_LSB:0] gainA2,
      input logic [GAINA1_MSB-GAINA1_LSB:0] gainA1);
      logic [CFG_WORD_W-1:0] word;
      word = '0;
      word[GAINA2_MSB:GAINA2_LSB] = gainA2;
      word[GAINA1_MSB:GAINA1_LSB] = gainA1;
      return word;
   endfunction

endpackage

// File: rtl/cfg_serial_tx_if.sv
// Controller-side request/status bundle of the serial configuration
// transmitter.
//   i_start      : request a transfer (controller -> transmitter)
//   i_gainA1     : 3-bit gain A1 value captured with the start
//   i_gainA2     : 2-bit gain A2 value captured with the start
//   o_busy       : transfer in progress (transmitter -> controller)
//   o_done       : one-cycle completion pulse
//   o_timeout    : sticky flag, backend never signalled ready
//   o_vco1_fast  : backend VCO comparison captured at completion
// The controller connects through the master modport, the transmitter
// through the slave modport.
interface cfg_serial_tx_if;

   logic       i_start;
   logic [2:0] i_gainA1;
   logic [1:0] i_gainA2;
   logic       o_busy;
   logic       o_done;
   logic       o_timeout;
   logic       o_vco1_fast;

   modport master (
      output i_start,
      output i_gainA1,
      output i_gainA2,
      input  o_busy,
      input  o_done,
      input  o_timeout,
      input  o_vco1_fast
   );

   modport slave (
      input  i_start,
      input  i_gainA1,
      input  i_gainA2,
      output o_busy,
      output o_done,
      output o_timeout,
      output o_vco1_fast
   );

endinterface

// File: rtl/cfg_clkdiv_phase.sv
// Phase counter that divides the system clock into serial-clock half
// periods.
//   clk     : system clock, rising edge
//   resetb  : synchronous active-low reset
//   restart : forces the count back to zero (holds it there while high)
//   enable  : advance the count this cycle
//   tc      : high on the last cycle of each CLK_DIV-cycle half period
module cfg_clkdiv_phase #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic resetb,
   input  logic restart,
   input  logic enable,
   output logic tc
);

   localparam int CNT_W = $clog2(CLK_DIV) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Counts 0..CLK_DIV-1 and wraps, so consecutive half periods follow each
   // other without a dead cycle; restart wins over enable.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         count <= '0;
      end else if (restart) begin
         count <= '0;
      end else if (enable) begin
         if (count == CNT_LAST) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // The terminal count is combinational so the FSM can change state on the
   // very edge that closes the half period.
   assign tc = enable && !restart && (count == CNT_LAST);

endmodule

// File: rtl/cfg_serial_tx.sv
// Serial configuration transmitter: shifts a 5-bit gain word MSB first on
// a divided serial clock, then waits (with a timeout) for the backend to
// report ready and captures its VCO comparison result.
//   i_clk        : sole clock, rising edge
//   i_resetbAll  : synchronous active-low reset
//   ctl          : controller request/status bundle (slave side)
//   i_ready      : backend ready indication
//   i_vco1_fast  : backend VCO comparison result
//   o_sclk       : serial clock to the backend
//   o_sdin       : serial data to the backend
// CLK_DIV is the o_sclk half period in i_clk cycles; READY_TIMEOUT bounds
// the number of cycles spent waiting for i_ready.
module cfg_serial_tx
   import cfg_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int READY_TIMEOUT = 64
) (
   input  logic            i_clk,
   input  logic            i_resetbAll,
   cfg_serial_tx_if.slave  ctl,
   input  logic            i_ready,
   input  logic            i_vco1_fast,
   output logic            o_sclk,
   output logic            o_sdin
);

   localparam int TMR_W = $clog2(READY_TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(READY_TIMEOUT - 1);

   cfg_state_t            state;
   logic [CFG_WORD_W-1:0] word;
   logic [2:0]            bit_idx;
   logic [2:0]            next_idx;
   logic [TMR_W-1:0]      wait_cnt;
   logic [CFG_WORD_W-1:0] start_word;
   logic                  phase_restart;
   logic                  phase_en;
   logic                  phase_tc;

   // The phase counter sits at zero while idle so the first half period
   // after an accepted start is a full CLK_DIV cycles long.
   assign phase_restart = (state == ST_IDLE);
   assign phase_en      = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
   assign start_word    = pack_word(ctl.i_gainA2, ctl.i_gainA1);
   assign next_idx      = bit_idx - 3'd1;

   cfg_clkdiv_phase #(
      .CLK_DIV (CLK_DIV)
   ) u_phase (
      .clk     (i_clk),
      .resetb  (i_resetbAll),
      .restart (phase_restart),
      .enable  (phase_en),
      .tc      (phase_tc)
   );

   // Main transfer FSM. Every output is registered here and updated on the
   // same edge as the state change, so each output already shows the value
   // belonging to the state being entered. Data only moves on the edge that
   // drops o_sclk, which keeps o_sdin stable across every rising edge.
   always_ff @(posedge i_clk) begin
      if (!i_resetbAll) begin
         state           <= ST_IDLE;
         word            <= '0;
         bit_idx         <= '0;
         wait_cnt        <= '0;
         o_sclk          <= 1'b0;
         o_sdin          <= 1'b0;
         ctl.o_busy      <= 1'b0;
         ctl.o_done      <= 1'b0;
         ctl.o_timeout   <= 1'b0;
         ctl.o_vco1_fast <= 1'b0;
      end else begin
         ctl.o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_sclk     <= 1'b0;
               o_sdin     <= 1'b0;
               ctl.o_busy <= 1'b0;
               if (ctl.i_start) begin
                  word          <= start_word;
                  bit_idx       <= 3'(CFG_WORD_W - 1);
                  o_sdin        <= start_word[CFG_WORD_W-1];
                  ctl.o_timeout <= 1'b0;
                  ctl.o_busy    <= 1'b1;
                  state         <= ST_SHIFT_LO;
               end
            end

            ST_SHIFT_LO: begin
               if (phase_tc) begin
                  o_sclk <= 1'b1;
                  state  <= ST_SHIFT_HI;
               end
            end

            ST_SHIFT_HI: begin
               if (phase_tc) begin
                  o_sclk <= 1'b0;
                  if (bit_idx == 3'd0) begin
                     o_sdin   <= 1'b0;
                     wait_cnt <= '0;
                     state    <= ST_WAIT_RDY;
                  end else begin
                     bit_idx <= next_idx;
                     o_sdin  <= word[next_idx];
                     state   <= ST_SHIFT_LO;
                  end
               end
            end

            ST_WAIT_RDY: begin
               if (i_ready) begin
                  ctl.o_done      <= 1'b1;
                  ctl.o_vco1_fast <= i_vco1_fast;
                  state           <= ST_DONE;
               end else if (wait_cnt == TMR_LAST) begin
                  ctl.o_timeout <= 1'b1;
                  ctl.o_busy    <= 1'b0;
                  state         <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_DONE: begin
               ctl.o_busy <= 1'b0;
               state      <= ST_IDLE;
            end

            default: begin
               o_sclk     <= 1'b0;
               o_sdin     <= 1'b0;
               ctl.o_busy <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_serial_tx.sv
// Directed self-checking bench for cfg_serial_tx. Instance A runs with
// CLK_DIV=2 / READY_TIMEOUT=8, instance B with CLK_DIV=1 and i_ready tied
// high. A small backend model shifts in o_sdin on every o_sclk rise; the
// expected frame words are queued when a start is driven and compared when
// the frame has been shifted out.
module tb_cfg_serial_tx;
   import cfg_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   logic a_ready, a_vco, a_sclk, a_sdin;
   logic b_ready, b_vco, b_sclk, b_sdin;

   int checks = 0;
   int errors = 0;

   logic [4:0] sb_q[$];

   // Backend model state, sampled on the falling edge
   logic       a_prev = 1'b0;
   logic       b_prev = 1'b0;
   logic [4:0] a_rx = '0;
   logic [4:0] b_rx = '0;
   int         a_rises = 0;
   int         b_rises = 0;
   int         a_dones = 0;
   int         b_dones = 0;

   cfg_serial_tx_if a_if ();
   cfg_serial_tx_if b_if ();

   cfg_serial_tx #(
      .CLK_DIV       (2),
      .READY_TIMEOUT (8)
   ) dut_a (
      .i_clk       (clk),
      .i_resetbAll (rstn),
      .ctl         (a_if.slave),
      .i_ready     (a_ready),
      .i_vco1_fast (a_vco),
      .o_sclk      (a_sclk),
      .o_sdin      (a_sdin)
   );

   cfg_serial_tx #(
      .CLK_DIV       (1),
      .READY_TIMEOUT (64)
   ) dut_b (
      .i_clk       (clk),
      .i_resetbAll (rstn),
      .ctl         (b_if.slave),
      .i_ready     (b_ready),
      .i_vco1_fast (b_vco),
      .o_sclk      (b_sclk),
      .o_sdin      (b_sdin)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   // Backend receivers: shift in data on each serial clock rise and count
   // rises and completion pulses for both instances.
   always @(negedge clk) begin
      a_prev <= a_sclk;
      b_prev <= b_sclk;
      if (a_sclk === 1'b1 && a_prev === 1'b0) begin
         a_rx    <= {a_rx[3:0], a_sdin};
         a_rises <= a_rises + 1;
      end
      if (b_sclk === 1'b1 && b_prev === 1'b0) begin
         b_rx    <= {b_rx[3:0], b_sdin};
         b_rises <= b_rises + 1;
      end
      if (a_if.o_done === 1'b1) a_dones <= a_dones + 1;
      if (b_if.o_done === 1'b1) b_dones <= b_dones + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives a one-cycle start on instance A (sel_b=0) or B (sel_b=1) and
   // queues the frame word the receiver should end up holding. Returns on
   // the falling edge right after the accepting edge.
   task automatic applyStimulus(input bit sel_b, input logic [2:0] a1,
                                input logic [1:0] a2);
      @(negedge clk);
      if (sel_b) begin
         b_if.i_start = 1'b1; b_if.i_gainA1 = a1; b_if.i_gainA2 = a2;
      end else begin
         a_if.i_start = 1'b1; a_if.i_gainA1 = a1; a_if.i_gainA2 = a2;
      end
      sb_q.push_back({a2, a1});
      @(negedge clk);
      a_if.i_start = 1'b0;
      b_if.i_start = 1'b0;
   endtask

   // Pops the oldest expected word and compares it with what the backend
   // model received, plus the decoded gain fields.
   task automatic checkFrame(input bit sel_b, input string tag);
      logic [4:0] exp_w;
      logic [4:0] rx;
      rx = sel_b ? b_rx : a_rx;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s observed=empty-queue expected=frame", tag);
      end else begin
         exp_w = sb_q.pop_front();
         checkOutput({tag, "_word"}, 8'(rx), 8'(exp_w));
         checkOutput({tag, "_gainA1"}, 8'(rx[GAINA1_MSB:GAINA1_LSB]), 8'(exp_w[2:0]));
         checkOutput({tag, "_gainA2"}, 8'(rx[GAINA2_MSB:GAINA2_LSB]), 8'(exp_w[4:3]));
      end
   endtask

   int rb, db;

   initial begin
      rstn = 1'b0;
      a_if.i_start = 1'b0; a_if.i_gainA1 = '0; a_if.i_gainA2 = '0;
      b_if.i_start = 1'b0; b_if.i_gainA1 = '0; b_if.i_gainA2 = '0;
      a_ready = 1'b0; a_vco = 1'b0;
      b_ready = 1'b1; b_vco = 1'b1;

      // Reset values
      step(2);
      checkOutput("rst_sclk", 8'(a_sclk), 8'h0);
      checkOutput("rst_sdin", 8'(a_sdin), 8'h0);
      checkOutput("rst_busy", 8'(a_if.o_busy), 8'h0);
      checkOutput("rst_done", 8'(a_if.o_done), 8'h0);
      checkOutput("rst_timeout", 8'(a_if.o_timeout), 8'h0);
      checkOutput("rst_vco", 8'(a_if.o_vco1_fast), 8'h0);
      rstn = 1'b1;
      step(2);

      // Frame 10101 with backend ready and vco=1
      a_vco = 1'b1;
      rb = a_rises; db = a_dones;
      applyStimulus(0, 3'b101, 2'b10);
      checkOutput("f1_busy_start", 8'(a_if.o_busy), 8'h1);
      checkOutput("f1_sdin_bit4", 8'(a_sdin), 8'h1);
      checkOutput("f1_sclk_start", 8'(a_sclk), 8'h0);
      step(19);
      checkOutput("f1_sclk_last_hi", 8'(a_sclk), 8'h1);
      checkOutput("f1_sdin_bit0", 8'(a_sdin), 8'h1);
      step(1);
      checkOutput("f1_wait_sclk", 8'(a_sclk), 8'h0);
      checkOutput("f1_wait_sdin", 8'(a_sdin), 8'h0);
      checkOutput("f1_wait_busy", 8'(a_if.o_busy), 8'h1);
      checkOutput("f1_rises", 8'(a_rises - rb), 8'd5);
      checkOutput("f1_no_done_yet", 8'(a_dones - db), 8'd0);
      checkFrame(0, "f1");
      a_ready = 1'b1;
      step(1);
      a_ready = 1'b0;
      checkOutput("f1_done", 8'(a_if.o_done), 8'h1);
      checkOutput("f1_vco", 8'(a_if.o_vco1_fast), 8'h1);
      checkOutput("f1_busy_in_done", 8'(a_if.o_busy), 8'h1);
      step(1);
      checkOutput("f1_done_clear", 8'(a_if.o_done), 8'h0);
      checkOutput("f1_busy_clear", 8'(a_if.o_busy), 8'h0);
      checkOutput("f1_done_count", 8'(a_dones - db), 8'd1);

      // Timeout with ready held low
      a_vco = 1'b0;
      rb = a_rises; db = a_dones;
      applyStimulus(0, 3'b011, 2'b01);
      step(20);
      checkOutput("to_wait_busy", 8'(a_if.o_busy), 8'h1);
      checkFrame(0, "to");
      step(7);
      checkOutput("to_not_yet", 8'(a_if.o_timeout), 8'h0);
      checkOutput("to_busy_before", 8'(a_if.o_busy), 8'h1);
      step(1);
      checkOutput("to_flag", 8'(a_if.o_timeout), 8'h1);
      checkOutput("to_busy_after", 8'(a_if.o_busy), 8'h0);
      checkOutput("to_vco_kept", 8'(a_if.o_vco1_fast), 8'h1);
      checkOutput("to_no_done", 8'(a_dones - db), 8'd0);

      // Next start clears timeout; a start during bit 2 high is ignored
      a_vco = 1'b1;
      rb = a_rises; db = a_dones;
      applyStimulus(0, 3'b110, 2'b11);
      checkOutput("ig_timeout_cleared", 8'(a_if.o_timeout), 8'h0);
      checkOutput("ig_busy", 8'(a_if.o_busy), 8'h1);
      step(10);
      checkOutput("ig_bit2_high", 8'(a_sclk), 8'h1);
      a_if.i_start = 1'b1; a_if.i_gainA1 = 3'b000; a_if.i_gainA2 = 2'b00;
      step(1);
      a_if.i_start = 1'b0;
      step(9);
      checkOutput("ig_wait_sclk", 8'(a_sclk), 8'h0);
      checkOutput("ig_rises", 8'(a_rises - rb), 8'd5);
      checkFrame(0, "ig");
      a_ready = 1'b1;
      step(1);
      a_ready = 1'b0;
      checkOutput("ig_done", 8'(a_if.o_done), 8'h1);
      step(11);
      checkOutput("ig_idle_busy", 8'(a_if.o_busy), 8'h0);
      checkOutput("ig_no_second_frame", 8'(a_rises - rb), 8'd5);
      checkOutput("ig_done_count", 8'(a_dones - db), 8'd1);

      // Reset during bit 3 aborts the frame
      applyStimulus(0, 3'b010, 2'b01);
      step(4);
      checkOutput("rs_bit3_sdin", 8'(a_sdin), 8'h1);
      checkOutput("rs_bit3_sclk", 8'(a_sclk), 8'h0);
      rstn = 1'b0;
      step(1);
      checkOutput("rs_sclk", 8'(a_sclk), 8'h0);
      checkOutput("rs_sdin", 8'(a_sdin), 8'h0);
      checkOutput("rs_busy", 8'(a_if.o_busy), 8'h0);
      checkOutput("rs_done", 8'(a_if.o_done), 8'h0);
      checkOutput("rs_timeout", 8'(a_if.o_timeout), 8'h0);
      checkOutput("rs_vco", 8'(a_if.o_vco1_fast), 8'h0);
      rstn = 1'b1;
      sb_q.delete();
      rb = a_rises; db = a_dones;
      applyStimulus(0, 3'b111, 2'b00);
      step(20);
      checkOutput("rs_new_rises", 8'(a_rises - rb), 8'd5);
      checkFrame(0, "rs_new");
      a_ready = 1'b1;
      step(1);
      a_ready = 1'b0;
      checkOutput("rs_new_done", 8'(a_if.o_done), 8'h1);
      step(2);

      // CLK_DIV=1 with ready already high
      rb = b_rises; db = b_dones;
      applyStimulus(1, 3'b001, 2'b11);
      checkOutput("b_busy", 8'(b_if.o_busy), 8'h1);
      checkOutput("b_sdin_bit4", 8'(b_sdin), 8'h1);
      checkOutput("b_sclk_lo", 8'(b_sclk), 8'h0);
      step(1);
      checkOutput("b_first_rise", 8'(b_sclk), 8'h1);
      step(9);
      checkOutput("b_wait_sclk", 8'(b_sclk), 8'h0);
      checkOutput("b_wait_done", 8'(b_if.o_done), 8'h0);
      checkOutput("b_wait_busy", 8'(b_if.o_busy), 8'h1);
      step(1);
      checkOutput("b_done", 8'(b_if.o_done), 8'h1);
      checkOutput("b_vco", 8'(b_if.o_vco1_fast), 8'h1);
      step(1);
      checkOutput("b_done_clear", 8'(b_if.o_done), 8'h0);
      checkOutput("b_busy_clear", 8'(b_if.o_busy), 8'h0);
      checkOutput("b_rises", 8'(b_rises - rb), 8'd5);
      checkOutput("b_done_count", 8'(b_dones - db), 8'd1);
      checkFrame(1, "b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
